// File: rtl/see_event_logger.sv
// SEE event logger: per-replica upset counters, MBU detection, and a scan FSM
// that serialises captured upset bits into timestamped records through a FIFO.

module see_replica_cnt #(
    parameter int W = 32
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic          en,
    input  logic          clr,
    input  logic [W-1:0]  mask,
    output logic [15:0]   count
);
    localparam int PW = $clog2(W + 1);

    logic [PW-1:0] pc;
    logic [16:0]   sum;

    always_comb begin
        pc = '0;
        for (int b = 0; b < W; b++) pc = pc + PW'(mask[b]);
    end

    assign sum = {1'b0, count} + 17'(pc);

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i)  count <= '0;
        else if (clr)     count <= '0;
        else if (en)      count <= sum[16] ? 16'hFFFF : sum[15:0];
    end
endmodule

module see_event_logger #(
    parameter  int W  = 32,
    parameter  int N  = 3,
    parameter  int D  = 8,
    localparam int RW = (N > 1) ? $clog2(N) : 1,
    localparam int BW = $clog2(W),
    localparam int DW = 32 + RW + BW
) (
    input  logic                 s_clk_i,
    input  logic                 s_resetn_i,
    input  logic                 s_enable_i,
    input  logic                 s_clear_i,
    input  logic [N-1:0][W-1:0]  s_upset_i,
    output logic                 s_evt_valid_o,
    input  logic                 s_evt_ready_i,
    output logic [DW-1:0]        s_evt_data_o,
    output logic [N-1:0][15:0]   s_count_o,
    output logic [15:0]          s_drop_o,
    output logic                 s_mbu_o
);
    localparam int AW = $clog2(D);

    typedef enum logic {IDLE, SCAN} state_t;
    typedef struct packed {
        logic [31:0]   ts;
        logic [RW-1:0] rep;
        logic [BW-1:0] bidx;
    } evt_t;

    state_t             state, state_n;
    logic [N-1:0][W-1:0] pend, pend_n, pend_clr;
    logic [31:0]        ts, ts_cap;
    logic               any_hit, mbu_hit, drop_hit, push, pop, full;
    logic [RW-1:0]      sel_rep;
    logic [BW-1:0]      sel_bit;
    logic               sel_found;
    logic [W-1:0]       seen, dup;

    evt_t               mem [D];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        cnt;

    assign any_hit  = s_enable_i && (|s_upset_i);
    assign drop_hit = (state != IDLE) && any_hit;

    // A bit seen in an earlier replica and again in this one is a coincidence.
    always_comb begin
        seen = '0;
        dup  = '0;
        for (int i = 0; i < N; i++) begin
            dup  = dup | (seen & s_upset_i[i]);
            seen = seen | s_upset_i[i];
        end
        mbu_hit = s_enable_i && (|dup);
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_lane
            see_replica_cnt #(.W(W)) u_cnt (
                .s_clk_i   (s_clk_i),
                .s_resetn_i(s_resetn_i),
                .en        (s_enable_i),
                .clr       (s_clear_i),
                .mask      (s_upset_i[g]),
                .count     (s_count_o[g])
            );
        end
    endgenerate

    // Lowest replica with pending bits, then lowest bit within it.
    always_comb begin
        sel_found = 1'b0;
        sel_rep   = '0;
        sel_bit   = '0;
        for (int i = 0; i < N; i++) begin
            if (!sel_found && (|pend[i])) begin
                sel_found = 1'b1;
                sel_rep   = RW'(i);
                for (int j = W - 1; j >= 0; j--)
                    if (pend[i][j]) sel_bit = BW'(j);
            end
        end
        pend_clr = pend;
        pend_clr[sel_rep][sel_bit] = 1'b0;
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        push    = 1'b0;
        case (state)
            IDLE: if (any_hit) begin
                state_n = SCAN;
                pend_n  = s_upset_i;
            end
            SCAN: if (!full) begin
                push   = 1'b1;
                pend_n = pend_clr;
                if (pend_clr == '0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state  <= IDLE;
            pend   <= '0;
            ts     <= '0;
            ts_cap <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            ts    <= ts + 32'd1;
            if (state == IDLE && any_hit) ts_cap <= ts;
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            s_drop_o <= '0;
            s_mbu_o  <= 1'b0;
        end else if (s_clear_i) begin
            s_drop_o <= '0;
            s_mbu_o  <= 1'b0;
        end else begin
            if (drop_hit && s_drop_o != 16'hFFFF) s_drop_o <= s_drop_o + 16'd1;
            if (mbu_hit) s_mbu_o <= 1'b1;
        end
    end

    // Full blocks the push even when a pop frees a slot this cycle.
    assign full          = (cnt == (AW+1)'(D));
    assign s_evt_valid_o = (cnt != '0);
    assign pop           = s_evt_valid_o && s_evt_ready_i;
    assign s_evt_data_o  = mem[rd_ptr];

    always_ff @(posedge s_clk_i) begin
        if (push) mem[wr_ptr] <= '{ts: ts_cap, rep: sel_rep, bidx: sel_bit};
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: doc/see_event_logger.md
Name: see_event_logger

Overview:
- Downstream consumer of the SEE upset-mask generator.
- Takes the N per-replica W-bit upset masks, counts upsets per replica, and flags same-bit coincidence across replicas (MBU).
- Serialises each set bit into a timestamped event record, buffered in a FIFO and drained over a valid/ready port to the testbench logger/scoreboard.

Parameters:
- W, 32, width of each upset mask.
- N, 3, number of replicas/masks (1..8).
- D, 8, event FIFO depth (power of 2, >=2).
- RW, (N>1 ? $clog2(N) : 1), replica index width (derived localparam).
- BW, $clog2(W), bit index width (derived localparam).

Ports:
- s_clk_i  input  1  clock.
- s_resetn_i  input  1  reset, asynchronous, active-low.
- s_enable_i  input  1  observation enable; masks are ignored when 0.
- s_clear_i  input  1  synchronous clear of counters/flags (FIFO untouched).
- s_upset_i  input  [W-1:0] x N  upset masks from the generator.
- s_evt_valid_o  output  1  FIFO head valid.
- s_evt_ready_i  input  1  consumer ready.
- s_evt_data_o  output  32+RW+BW  {timestamp[31:0], replica, bit}.
- s_count_o  output  [15:0] x N  per-replica upset bit count.
- s_drop_o  output  16  cycles whose upsets could not be captured.
- s_mbu_o  output  1  sticky same-bit multi-replica flag.

Behaviour:
- Reset values: all outputs 0; FSM IDLE; timestamp 0; FIFO empty; pending mask 0.
- Timestamp: 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF->0. Not affected by s_clear_i.
- Counters: when s_enable_i=1, s_count_o[i] += popcount(s_upset_i[i]), saturating at 0xFFFF. Counting is independent of FSM/FIFO state.
- MBU: when s_enable_i=1, N>=2, and any bit j is set in >=2 replicas in the same cycle, s_mbu_o <= 1 and stays set until s_clear_i.
- s_clear_i:
  - Zeroes s_count_o, s_drop_o and s_mbu_o at the next edge.
  - Clear wins over a same-cycle increment/set.
- FSM IDLE:
  - If s_enable_i=1 and any mask is nonzero: latch all masks into pend, latch the current timestamp into ts_cap, go to SCAN.
- FSM SCAN, one cycle per step:
  - sel = lowest replica i with pend[i]!=0; within it, lowest bit j.
  - If FIFO not full: push {ts_cap, i, j} and clear pend[i][j]. If pend becomes 0 after the clear, go to IDLE.
  - If FIFO full: hold pend and stay in SCAN (stall).
  - Full gates the push even if a pop occurs in the same cycle (no bypass credit).
- Drops: in any cycle where the FSM is not IDLE and s_enable_i=1 and any mask is nonzero, s_drop_o += 1 (saturating 0xFFFF). Those masks are not captured; they are still counted in s_count_o and checked for MBU.
- Latency:
  - Mask presented in cycle t: captured at edge t; first record pushed at edge t+1; s_evt_valid_o high from cycle t+2.
  - The FSM returns to IDLE at the edge that pushes the last bit, and can capture again in the following cycle.
- FIFO:
  - Pop on s_evt_valid_o & s_evt_ready_i.
  - Push and pop in the same cycle are both allowed when not full.
  - s_evt_data_o is the head entry; it is undefined when not valid, and the bench must not check it then.
  - Pointers wrap modulo D.
- Mid-operation reset: asynchronous assertion immediately empties the FIFO, drops pend and forces IDLE, as in the reset values.
- s_enable_i deassertion during SCAN does not abort the scan; already captured bits are still logged.

Test Plan:
- Single upset: N=3, W=32, s_upset_i[1]=0x0000_0010 for one cycle at timestamp 5, ready=1 -> one record {5,1,4}; s_count_o[1]=1; s_mbu_o=0; s_drop_o=0.
- Multi-replica ordering: masks [0]=0x1, [1]=0x0, [2]=0x8000_0002 at timestamp T -> records in order {T,0,0}, {T,2,1}, {T,2,31}, one per cycle; s_count_o={1,0,2}.
- Coincidence: [0]=0x4, [2]=0x4 in the same cycle -> s_mbu_o=1 from the next cycle and held; pulse s_clear_i -> s_mbu_o=0 and counts 0.
- Backpressure: ready=0, D=8, inject 10 single-bit upsets in 10 separate cycles -> FIFO fills to 8 and the FSM stalls holding the 9th. Upsets arriving during SCAN increment s_drop_o (s_drop_o=1 at the end); s_count_o counts all 10. Raising ready drains records with strictly increasing timestamps.
- Drop saturation: hold ready=0 with a nonzero mask every cycle for 70000 cycles -> s_drop_o=0xFFFF and s_count_o saturated at 0xFFFF.
- Reset mid-scan: assert s_resetn_i=0 while 3 bits are pending -> s_evt_valid_o=0 and all counters 0 immediately. After release, a new upset is logged with a timestamp restarted from 0.
